// File: rtl/pixel_readout_rx_if.sv
// pixel_readout_rx_if: valid/ready pixel stream carrying row/column and framing tags.
interface pixel_readout_rx_if #(
  parameter int data_w = 8,
  parameter int row_w = 1,
  parameter int col_w = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [data_w-1:0] out_data;
  logic [row_w-1:0]  out_row;
  logic [col_w-1:0]  out_col;
  logic              out_sof;
  logic              out_eol;
  modport master (
    output out_valid, out_data, out_row, out_col, out_sof, out_eol,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_data, out_row, out_col, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/pixel_readout_rx.sv
// pixel_readout_rx: captures pixel array readout frames into a ping-pong buffer and streams them out.
module pixel_readout_rx #(
  parameter int array_width = 2,
  parameter int array_height = 2,
  parameter int counter_width = 8,
  parameter int pixel_count = array_width * array_height
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [counter_width-1:0] pixel_out,
  input  logic                     clear_overrun,
  output logic                     overrun,
  pixel_readout_rx_if.master       stream
);
  localparam int idx_w = pixel_count > 1 ? $clog2(pixel_count) : 1;
  localparam int row_w = array_height > 1 ? $clog2(array_height) : 1;
  localparam int col_w = array_width > 1 ? $clog2(array_width) : 1;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
  wr_state_t              wr_state, wr_state_n;
  logic [idx_w-1:0]       wr_idx, rd_idx;
  logic [row_w-1:0]       rd_row;
  logic [col_w-1:0]       rd_col;
  logic                   wr_bank, rd_bank;
  logic [1:0]             full, full_n;
  logic [counter_width-1:0] mem [2][pixel_count];
  logic wr_first, drop_start, wr_en, wr_last, wr_done, fire, rd_last, col_last;
  // A frame's fate (keep or drop) is decided on its first sample; the FSM remembers it.
  always_comb begin
    wr_first   = read && wr_state == W_IDLE;
    drop_start = wr_first && full[wr_bank];
    wr_en      = read && (wr_state == W_FILL || (wr_first && !full[wr_bank]));
    wr_last    = wr_idx == idx_w'(pixel_count - 1);
    wr_done    = wr_en && wr_last;
    wr_state_n = !read ? wr_state :
                 wr_last ? W_IDLE :
                 wr_state != W_IDLE ? wr_state :
                 drop_start ? W_DROP : W_FILL;
    fire       = full[rd_bank] && stream.out_ready;
    rd_last    = rd_idx == idx_w'(pixel_count - 1);
    col_last   = rd_col == col_w'(array_width - 1);
    full_n     = full;
    if (wr_done) full_n[wr_bank] = 1'b1;
    if (fire && rd_last) full_n[rd_bank] = 1'b0;
  end
  always_ff @(posedge system_clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_idx   <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      rd_bank  <= 1'b0;
      full     <= '0;
      overrun  <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      full     <= full_n;
      if (read) wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (fire) begin
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
        rd_col <= col_last ? '0 : rd_col + 1'b1;
        rd_row <= rd_last ? '0 : col_last ? rd_row + 1'b1 : rd_row;
        if (rd_last) rd_bank <= ~rd_bank;
      end
      overrun <= drop_start | (overrun & ~clear_overrun);
    end
  end
  // Bank storage is deliberately left out of reset.
  always_ff @(posedge system_clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= pixel_out;
  end
  assign stream.out_valid = full[rd_bank];
  assign stream.out_data  = mem[rd_bank][rd_idx];
  assign stream.out_row   = rd_row;
  assign stream.out_col   = rd_col;
  assign stream.out_sof   = rd_idx == '0;
  assign stream.out_eol   = col_last;
endmodule

// File: tb/tb_pixel_readout_rx.sv
// tb_pixel_readout_rx: directed scenario tests for the 2x2 pixel readout receiver.
module tb_pixel_readout_rx;
  logic       clk = 1'b0;
  logic       reset, read, clear_overrun, overrun;
  logic [7:0] pixel_out;
  int         errors = 0;
  int         checks = 0;
  pixel_readout_rx_if #(.data_w(8), .row_w(1), .col_w(1)) bus ();
  pixel_readout_rx #(.array_width(2), .array_height(2), .counter_width(8)) dut (
    .system_clk(clk),
    .reset(reset),
    .read(read),
    .pixel_out(pixel_out),
    .clear_overrun(clear_overrun),
    .overrun(overrun),
    .stream(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      got = {bus.out_valid, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol, overrun};
      checks++;
      if (got !== 6'b000100) begin
        errors++;
        $display("FAIL reset[%0d]: {valid,row,col,sof,eol,overrun}=%b expected 000100", i, got);
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_single();
    logic [7:0]  v [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [12:0] got, exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read = 1'b1;
      pixel_out = v[i];
      step();
      checks++;
      if (bus.out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL single_latency[%0d]: valid=%b expected %b", i, bus.out_valid, i == 3);
      end
    end
    read = 1'b0;
    for (int b = 0; b < 4; b++) begin
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      exp = {1'b1, v[b], 1'(b / 2), 1'(b % 2), b == 0, b % 2 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_beat[%0d]: got %h expected %h", b, got, exp);
      end
      step();
    end
    checks++;
    if ({bus.out_valid, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL single_end: {valid,overrun}=%b expected 00", {bus.out_valid, overrun});
    end
  endtask
  task automatic test_backpressure();
    logic [7:0]  v [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [12:0] got, exp;
    int          b = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read = 1'b1;
      pixel_out = v[i];
      step();
    end
    read = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = pat[c];
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      exp = {1'b1, v[b], 1'(b / 2), 1'(b % 2), b == 0, b % 2 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %h expected %h", c, got, exp);
      end
      step();
      if (pat[c]) b++;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_end: valid=%b expected 0", bus.out_valid);
    end
  endtask
  task automatic test_overrun();
    logic [12:0] got, exp;
    bus.out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) begin
        read = 1'b1;
        pixel_out = 8'(f * 4 + i + 1);
        clear_overrun = (f == 3 && i == 0);
        step();
        if (f == 1 && i == 3) begin
          checks++;
          if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: overrun=%b expected 0", overrun);
          end
        end
        if (f >= 2 && i == 0) begin
          checks++;
          if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set[frame %0d]: overrun=%b expected 1", f, overrun);
          end
        end
      end
    end
    read = 1'b0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      exp = {1'b1, 8'(b + 1), 1'((b % 4) / 2), 1'(b % 2), b % 4 == 0, b % 2 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overrun_drain[%0d]: got %h expected %h", b, got, exp);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_dropped_frame: valid=%b expected 0", bus.out_valid);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b expected 0", overrun);
    end
  endtask
  task automatic test_gaps();
    logic        rv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  pv [7] = '{8'd1, 8'd99, 8'd2, 8'd3, 8'd98, 8'd97, 8'd4};
    logic [12:0] got, exp;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      read = rv[c];
      pixel_out = pv[c];
      step();
      checks++;
      if (bus.out_valid !== (c == 6)) begin
        errors++;
        $display("FAIL gaps_valid[%0d]: valid=%b expected %b", c, bus.out_valid, c == 6);
      end
    end
    read = 1'b0;
    for (int b = 0; b < 4; b++) begin
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      exp = {1'b1, 8'(b + 1), 1'(b / 2), 1'(b % 2), b == 0, b % 2 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gaps_beat[%0d]: got %h expected %h", b, got, exp);
      end
      step();
    end
  endtask
  task automatic test_reset_mid();
    logic [12:0] got, exp;
    logic [5:0]  rg;
    bus.out_ready = 1'b1;
    read = 1'b1;
    pixel_out = 8'd7;
    step();
    pixel_out = 8'd8;
    step();
    read = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      rg = {bus.out_valid, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol, overrun};
      checks++;
      if (rg !== 6'b000100) begin
        errors++;
        $display("FAIL reset_mid_hold[%0d]: {valid,row,col,sof,eol,overrun}=%b expected 000100", i, rg);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read = 1'b1;
      pixel_out = 8'(i + 1);
      step();
      checks++;
      if (bus.out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL reset_mid_valid[%0d]: valid=%b expected %b", i, bus.out_valid, i == 3);
      end
    end
    read = 1'b0;
    for (int b = 0; b < 4; b++) begin
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      exp = {1'b1, 8'(b + 1), 1'(b / 2), 1'(b % 2), b == 0, b % 2 == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_beat[%0d]: got %h expected %h", b, got, exp);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_end: valid=%b expected 0", bus.out_valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [12:0] got, exp;
    int          k;
    bus.out_ready = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      read = n <= 8;
      pixel_out = 8'(20 + n);
      step();
      k = n - 4;
      got = {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol};
      if (n >= 4 && n <= 11) begin
        exp = {1'b1, 8'(21 + k), 1'((k % 4) / 2), 1'(k % 2), k % 4 == 0, k % 2 == 1};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", n, got, exp);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back_idle[%0d]: valid=%b expected 0", n, bus.out_valid);
        end
      end
    end
    read = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_overrun: overrun=%b expected 0", overrun);
    end
  endtask
  initial begin
    reset = 1'b1;
    read = 1'b0;
    pixel_out = '0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
